// File: rtl/outport_ctrl_pkg.sv
// Shared flit-type codes, output-arbiter state codes and credit depth for the
// output-port controller and the blocks that sit next to it.
package outport_ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_HEAD     = 2'd0,
    TYPE_DATA     = 2'd1,
    TYPE_TAIL     = 2'd2,
    TYPE_HEADTAIL = 2'd3
  } flit_type_e;

  typedef enum logic {
    OA_IDLE = 1'b0,
    OA_BUSY = 1'b1
  } oa_state_e;

  localparam int OVC_CREDITS = 4;

  // A flit of either of these types is the last one of its packet.
  function automatic logic ends_packet(input logic [1:0] flit_type);
    return (flit_type == TYPE_TAIL) || (flit_type == TYPE_HEADTAIL);
  endfunction

endpackage

// File: rtl/outport_ctrl_rr_arb.sv
// Combinational round-robin picker: returns the first set bit of mask at or
// after ptr, searching cyclically, as both a one-hot vector and an index.
module outport_ctrl_rr_arb #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         vld
);

  logic [W-1:0] pos;

  // NOTE: every variable written here gets a value before any branch, so no
  // path leaves one holding its old value and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = W'((int'(ptr) + i) % N);
      if (!vld && mask[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_ctrl.sv
// Output physical-channel controller: per-VC credit and packet-lock tracking
// plus a packet-granular round-robin grant of the switch output to input ports.
module outport_ctrl
  import outport_ctrl_pkg::*;
#(
  parameter int NPORT   = 5,
  parameter int NVCH    = 2,
  parameter int VCHW    = 1,
  parameter int CREDITS = OVC_CREDITS,
  parameter int CNTW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NPORT-1:0]      req_i,
  input  logic [NPORT*VCHW-1:0] req_vch_i,
  output logic [NPORT-1:0]      grt_o,
  input  logic                  send_i,
  input  logic [1:0]            send_type_i,
  input  logic [VCHW-1:0]       send_vch_i,
  input  logic [NVCH-1:0]       credit_i,
  output logic [NVCH-1:0]       irdy_o,
  output logic [NVCH-1:0]       ilck_o,
  output logic                  err_o
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [CNTW-1:0]  cnt     [NVCH];
  logic [CNTW-1:0]  cnt_nxt [NVCH];
  logic [NVCH-1:0]  lck, lck_nxt;
  logic [NVCH-1:0]  snd;
  logic             flow_err;
  logic             err;

  oa_state_e        state, state_nxt;
  logic [NPORT-1:0] grt, grt_nxt;
  logic [PW-1:0]    win, win_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic             idle_send;

  logic [NPORT-1:0] cand;
  logic [VCHW-1:0]  vch;
  logic [NPORT-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;

  always_comb begin
    snd = '0;
    for (int v = 0; v < NVCH; v++) begin
      snd[v] = send_i && (send_vch_i == VCHW'(v));
    end
  end

  // A send and a returned credit on the same VC cancel out.
  always_comb begin
    flow_err = 1'b0;
    lck_nxt  = lck;
    for (int v = 0; v < NVCH; v++) begin
      cnt_nxt[v] = cnt[v];
      if (snd[v] && !credit_i[v]) begin
        if (cnt[v] == '0) flow_err = 1'b1;
        else              cnt_nxt[v] = cnt[v] - 1'b1;
      end else if (credit_i[v] && !snd[v]) begin
        if (cnt[v] == CNTW'(CREDITS)) flow_err = 1'b1;
        else                          cnt_nxt[v] = cnt[v] + 1'b1;
      end
      if (snd[v]) begin
        if (send_type_i == TYPE_HEAD) begin
          if (lck[v]) flow_err = 1'b1;
          lck_nxt[v] = 1'b1;
        end else if (send_type_i == TYPE_TAIL) begin
          lck_nxt[v] = 1'b0;
        end
      end
    end
  end

  // NOTE: the counter array is only NVCH entries of flops, not a RAM, so it
  // is reset with everything else; a true memory would be left unreset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < NVCH; v++) cnt[v] <= CNTW'(CREDITS);
      lck <= '0;
      err <= 1'b0;
    end else begin
      for (int v = 0; v < NVCH; v++) cnt[v] <= cnt_nxt[v];
      lck <= lck_nxt;
      err <= err | flow_err | idle_send;
    end
  end

  always_comb begin
    for (int v = 0; v < NVCH; v++) irdy_o[v] = (cnt[v] != '0);
  end

  assign ilck_o = lck;
  assign err_o  = err;
  assign grt_o  = grt;

  // A port may compete only if its target VC has room and no packet owns it.
  always_comb begin
    cand = '0;
    vch  = '0;
    for (int p = 0; p < NPORT; p++) begin
      vch     = req_vch_i[p*VCHW +: VCHW];
      cand[p] = req_i[p] & irdy_o[vch] & ~lck[vch];
    end
  end

  outport_ctrl_rr_arb #(
    .N (NPORT),
    .W (PW)
  ) u_rr_arb (
    .mask  (cand),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  always_comb begin
    state_nxt = state;
    grt_nxt   = grt;
    win_nxt   = win;
    ptr_nxt   = ptr;
    idle_send = 1'b0;
    case (state)
      OA_IDLE: begin
        idle_send = send_i;
        if (pick_vld) begin
          state_nxt = OA_BUSY;
          grt_nxt   = pick;
          win_nxt   = pick_idx;
        end
      end
      OA_BUSY: begin
        // A dropped request mid-packet is an abort and releases like a tail.
        if ((send_i && ends_packet(send_type_i)) || !req_i[win]) begin
          state_nxt = OA_IDLE;
          grt_nxt   = '0;
          ptr_nxt   = (win == PW'(NPORT - 1)) ? '0 : win + 1'b1;
        end
      end
      default: state_nxt = OA_IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state <= OA_IDLE;
      grt   <= '0;
      win   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grt   <= grt_nxt;
      win   <= win_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_outport_ctrl.sv
// Bench for outport_ctrl: directed scenarios plus a randomized run against a
// behavioural model of credits, locks and packet-level round-robin grants.
module tb_outport_ctrl;
  import outport_ctrl_pkg::*;

  localparam int NPORT   = 5;
  localparam int NVCH    = 2;
  localparam int VCHW    = 1;
  localparam int CREDITS = 4;
  localparam int CNTW    = 3;

  logic                  clk;
  logic                  rst_;
  logic [NPORT-1:0]      req;
  logic [NPORT*VCHW-1:0] req_vch;
  logic [NPORT-1:0]      grt;
  logic                  send;
  logic [1:0]            send_type;
  logic [VCHW-1:0]       send_vch;
  logic [NVCH-1:0]       credit;
  logic [NVCH-1:0]       irdy;
  logic [NVCH-1:0]       ilck;
  logic                  err;

  int n_cmp;
  int n_bad;

  int m_cnt [NVCH];
  bit m_lck [NVCH];
  bit m_busy;
  int m_win;
  int m_ptr;
  bit m_err;

  outport_ctrl #(
    .NPORT   (NPORT),
    .NVCH    (NVCH),
    .VCHW    (VCHW),
    .CREDITS (CREDITS),
    .CNTW    (CNTW)
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .req_i       (req),
    .req_vch_i   (req_vch),
    .grt_o       (grt),
    .send_i      (send),
    .send_type_i (send_type),
    .send_vch_i  (send_vch),
    .credit_i    (credit),
    .irdy_o      (irdy),
    .ilck_o      (ilck),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int u = 0; u < NVCH; u++) begin
      m_cnt[u] = CREDITS;
      m_lck[u] = 1'b0;
    end
    m_busy = 1'b0;
    m_win  = 0;
    m_ptr  = 0;
    m_err  = 1'b0;
  endfunction

  // One clock of the output-port rules, applied to the inputs now driven.
  function automatic void model_step();
    int nc [NVCH];
    bit nl [NVCH];
    bit nbusy;
    int nwin;
    int nptr;
    bit nerr;
    bit found;
    nc = m_cnt;
    nl = m_lck;
    nbusy = m_busy;
    nwin = m_win;
    nptr = m_ptr;
    nerr = m_err;
    found = 1'b0;
    if (!m_busy) begin
      if (send) nerr = 1'b1;
      for (int k = 0; k < NPORT; k++) begin
        int p;
        int v;
        p = (m_ptr + k) % NPORT;
        v = int'(req_vch[p*VCHW +: VCHW]);
        if (!found && req[p] && m_cnt[v] > 0 && !m_lck[v]) begin
          found = 1'b1;
          nbusy = 1'b1;
          nwin  = p;
        end
      end
    end else if ((send && (send_type == TYPE_TAIL || send_type == TYPE_HEADTAIL)) || !req[m_win]) begin
      nbusy = 1'b0;
      nptr  = (m_win + 1) % NPORT;
    end
    for (int u = 0; u < NVCH; u++) begin
      bit s;
      s = send && (int'(send_vch) == u);
      if (s && !credit[u]) begin
        if (m_cnt[u] == 0) nerr = 1'b1;
        else nc[u] = m_cnt[u] - 1;
      end else if (credit[u] && !s) begin
        if (m_cnt[u] == CREDITS) nerr = 1'b1;
        else nc[u] = m_cnt[u] + 1;
      end
      if (s && send_type == TYPE_HEAD) begin
        if (m_lck[u]) nerr = 1'b1;
        nl[u] = 1'b1;
      end
      if (s && send_type == TYPE_TAIL) nl[u] = 1'b0;
    end
    m_cnt = nc;
    m_lck = nl;
    m_busy = nbusy;
    m_win = nwin;
    m_ptr = nptr;
    m_err = nerr;
  endfunction

  function automatic logic [NPORT-1:0] exp_grt();
    return m_busy ? (NPORT'(1) << m_win) : '0;
  endfunction

  function automatic logic [NVCH-1:0] exp_irdy();
    logic [NVCH-1:0] r;
    for (int u = 0; u < NVCH; u++) r[u] = (m_cnt[u] > 0);
    return r;
  endfunction

  function automatic logic [NVCH-1:0] exp_ilck();
    logic [NVCH-1:0] r;
    for (int u = 0; u < NVCH; u++) r[u] = m_lck[u];
    return r;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    req_vch = '0;
    send = 1'b0;
    send_type = TYPE_DATA;
    send_vch = '0;
    credit = '0;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL reset_grt got=%b want=%b", grt, 5'b00000); end
    n_cmp++; if (ilck !== 2'b00) begin n_bad++; $display("FAIL reset_ilck got=%b want=%b", ilck, 2'b00); end
    n_cmp++; if (irdy !== 2'b11) begin n_bad++; $display("FAIL reset_irdy got=%b want=%b", irdy, 2'b11); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=%b", err, 1'b0); end
  endtask

  task automatic test_single_packet();
    do_reset();
    req = 5'b00100;
    req_vch = 5'b00100;
    step();
    n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL pkt_grant got=%b want=%b", grt, 5'b00100); end
    send = 1'b1; send_vch = 1'b1; send_type = TYPE_HEAD;
    step();
    n_cmp++; if (ilck !== 2'b10) begin n_bad++; $display("FAIL pkt_lock_head got=%b want=%b", ilck, 2'b10); end
    send_type = TYPE_DATA;
    step();
    n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL pkt_hold got=%b want=%b", grt, 5'b00100); end
    send_type = TYPE_TAIL;
    step();
    n_cmp++; if (ilck !== 2'b00) begin n_bad++; $display("FAIL pkt_lock_tail got=%b want=%b", ilck, 2'b00); end
    n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL pkt_release got=%b want=%b", grt, 5'b00000); end
    send = 1'b0;
    req = 5'b01001;
    req_vch = 5'b00000;
    step();
    n_cmp++; if (grt !== 5'b01000) begin n_bad++; $display("FAIL pkt_ptr3 got=%b want=%b", grt, 5'b01000); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL pkt_err got=%b want=%b", err, 1'b0); end
  endtask

  task automatic test_round_robin();
    int order [4];
    order = '{0, 1, 4, 0};
    do_reset();
    req = 5'b10011;
    req_vch = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      send = 1'b0;
      step();
      n_cmp++; if (grt !== (NPORT'(1) << order[k])) begin n_bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, grt, NPORT'(1) << order[k]); end
      send = 1'b1;
      send_type = TYPE_HEADTAIL;
      send_vch = req_vch[order[k]];
      step();
      n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL rr_idle%0d got=%b want=%b", k, grt, 5'b00000); end
    end
    send = 1'b0;
  endtask

  task automatic test_credits();
    do_reset();
    req = 5'b00010;
    req_vch = 5'b00000;
    step();
    send = 1'b1; send_vch = 1'b0;
    send_type = TYPE_HEAD; step();
    send_type = TYPE_DATA; step();
    send_type = TYPE_DATA; step();
    send_type = TYPE_TAIL; step();
    send = 1'b0;
    n_cmp++; if (irdy !== 2'b10) begin n_bad++; $display("FAIL cred_empty got=%b want=%b", irdy, 2'b10); end
    step();
    step();
    n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL cred_block got=%b want=%b", grt, 5'b00000); end
    credit = 2'b01;
    step();
    credit = 2'b00;
    n_cmp++; if (irdy !== 2'b11) begin n_bad++; $display("FAIL cred_return got=%b want=%b", irdy, 2'b11); end
    n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL cred_nograntyet got=%b want=%b", grt, 5'b00000); end
    step();
    n_cmp++; if (grt !== 5'b00010) begin n_bad++; $display("FAIL cred_grant got=%b want=%b", grt, 5'b00010); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL cred_err got=%b want=%b", err, 1'b0); end
  endtask

  task automatic test_send_and_credit();
    do_reset();
    req = 5'b00001;
    req_vch = 5'b00000;
    step();
    send = 1'b1; send_vch = 1'b0;
    send_type = TYPE_HEAD; step();
    send_type = TYPE_DATA; step();
    credit = 2'b01;
    step();
    credit = 2'b00;
    step();
    n_cmp++; if (irdy !== 2'b11) begin n_bad++; $display("FAIL both_cnt1 got=%b want=%b", irdy, 2'b11); end
    send_type = TYPE_TAIL;
    step();
    send = 1'b0;
    n_cmp++; if (irdy !== 2'b10) begin n_bad++; $display("FAIL both_cnt0 got=%b want=%b", irdy, 2'b10); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL both_err got=%b want=%b", err, 1'b0); end
  endtask

  task automatic test_errors();
    do_reset();
    credit = 2'b10;
    step();
    credit = 2'b00;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_overflow got=%b want=%b", err, 1'b1); end
    n_cmp++; if (irdy !== 2'b11) begin n_bad++; $display("FAIL err_ovf_irdy got=%b want=%b", irdy, 2'b11); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got=%b want=%b", err, 1'b0); end
    send = 1'b1; send_type = TYPE_DATA; send_vch = 1'b1;
    step();
    send = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_send got=%b want=%b", err, 1'b1); end
    step();
    step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=%b", err, 1'b1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 5'b00001;
    req_vch = 5'b00000;
    step();
    send = 1'b1; send_vch = 1'b0; send_type = TYPE_HEAD;
    step();
    n_cmp++; if (ilck !== 2'b01) begin n_bad++; $display("FAIL ar_locked got=%b want=%b", ilck, 2'b01); end
    #3;
    clear_inputs();
    rst_ = 1'b1;
    #1;
    n_cmp++; if (grt !== 5'b00000) begin n_bad++; $display("FAIL ar_grt got=%b want=%b", grt, 5'b00000); end
    n_cmp++; if (ilck !== 2'b00) begin n_bad++; $display("FAIL ar_ilck got=%b want=%b", ilck, 2'b00); end
    n_cmp++; if (irdy !== 2'b11) begin n_bad++; $display("FAIL ar_irdy got=%b want=%b", irdy, 2'b11); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 75 == 74) do_reset();
      req = NPORT'($urandom);
      req_vch = (NPORT*VCHW)'($urandom);
      send = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      send_type = 2'($urandom_range(0, 3));
      send_vch = VCHW'($urandom);
      for (int u = 0; u < NVCH; u++) credit[u] = ($urandom_range(0, 3) == 0);
      step();
      n_cmp++; if (grt !== exp_grt()) begin n_bad++; $display("FAIL rnd_grt c=%0d got=%b want=%b", c, grt, exp_grt()); end
      n_cmp++; if (irdy !== exp_irdy()) begin n_bad++; $display("FAIL rnd_irdy c=%0d got=%b want=%b", c, irdy, exp_irdy()); end
      n_cmp++; if (ilck !== exp_ilck()) begin n_bad++; $display("FAIL rnd_ilck c=%0d got=%b want=%b", c, ilck, exp_ilck()); end
      n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err, m_err); end
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_ = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credits();
    test_send_and_credit();
    test_errors();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/outport_ctrl.md
Name: outport_ctrl

Overview:
- Output-side counterpart of the input virtual-channel state machine.
- One instance per output physical channel of a router. It produces the per-VC ready (`irdy_o`) and lock (`ilck_o`) signals, and the per-input-port grant (`grt_o`), that input VCs consume while in the VSA/ST stages.
- Tracks downstream buffer credits per output VC and packet-level VC locks.
- Arbitrates the output switch port among input ports round-robin, holding each grant for a whole packet.

Parameters:
- NPORT, 5, number of input ports competing for this output.
- NVCH, 2, number of virtual channels on the output link.
- VCHW, 1, width of a VC index (clog2 of NVCH, minimum 1).
- CREDITS, 4, downstream buffer depth per VC, in flits.
- CNTW, 3, credit counter width (holds 0..CREDITS).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_, input, 1, reset; asynchronous, active-high (rst_=1 resets).
- req_i, input, NPORT, per-input-port request for this output.
- req_vch_i, input, NPORT*VCHW, target output VC of each requester; port p occupies bits [p*VCHW +: VCHW].
- grt_o, output, NPORT, one-hot grant; all zero when idle.
- send_i, input, 1, a flit crosses this output this cycle.
- send_type_i, input, 2, type of the flit being sent; encoded with the TYPE_* codes in define.h.
- send_vch_i, input, VCHW, output VC of the flit being sent.
- credit_i, input, NVCH, per-VC pulse: downstream freed one slot.
- irdy_o, output, NVCH, VC v has at least one credit.
- ilck_o, output, NVCH, VC v is held by an in-flight packet.
- err_o, output, 1, sticky protocol-error flag.

Behaviour:
- Reset values:
  - credit counters cnt[v]=CREDITS, so irdy_o is all ones.
  - ilck_o=0, grt_o=0, err_o=0.
  - Arbiter state=IDLE, round-robin pointer ptr=0.
- irdy_o[v] = (cnt[v]!=0). It is combinational from registers only, never from inputs.
- Credit update, per VC, at each edge:
  - send_i on v only: cnt decrements.
  - credit_i[v] only: cnt increments.
  - Both in the same cycle: cnt is unchanged.
  - Send when cnt==0: cnt stays 0 and err_o is set.
  - Credit when cnt==CREDITS (with no send): cnt stays CREDITS and err_o is set.
  - Effect is visible on irdy_o one cycle after the event.
- Lock update on send_i:
  - HEAD type: sets ilck_o[send_vch_i] at the next edge.
  - TAIL type: clears ilck_o[send_vch_i] at the next edge.
  - HEADTAIL and DATA types: leave the lock unchanged.
  - HEAD on an already locked VC sets err_o; the lock stays set.
- Arbiter FSM, IDLE:
  - Candidate ports are those with req_i[p]=1, irdy_o[req_vch_p]=1 and ilck_o[req_vch_p]=0.
  - Winner is the first candidate at or after ptr, searching cyclically.
  - If a winner exists: grt_o is set one-hot to the winner at the next edge and the FSM moves to BUSY.
  - Latency: request in cycle n, grant visible in cycle n+1.
- Arbiter FSM, BUSY:
  - grt_o is held stable. Credits and locks of other VCs do not affect it.
  - On send_i with type TAIL or HEADTAIL: next state is IDLE, grt_o goes to 0 and ptr becomes (winner+1) mod NPORT. No new grant is issued in that same edge.
  - If req_i[winner] drops before the tail, treat it as an abort: release exactly as on a tail, with no err_o.
- send_i asserted while in IDLE sets err_o; the counter and lock updates still apply.
- err_o is sticky and cleared only by reset.
- Reset asserted mid-packet: all state returns to reset values immediately, since reset is asynchronous.

Decomposition:
- define.h holds TYPE_HEAD, TYPE_DATA, TYPE_TAIL and TYPE_HEADTAIL.
- Add OVC_CREDITS and the arbiter state codes OA_IDLE/OA_BUSY to define.h.
- One sub-module, rr_arb: combinational round-robin pick taking a candidate mask and ptr and producing a one-hot winner. It is reusable by other output ports.

Test Plan:
- Reset, then port 2 requests VC 1 -> grt_o=00100 next cycle. Send HEAD then DATA then TAIL on VC 1 -> ilck_o[1]=1 after HEAD and 0 after TAIL, grt_o=0 after TAIL, ptr=3.
- Ports 0, 1 and 4 request continuously, each packet HEADTAIL -> grants go 0, 1, 4, 0 with one idle cycle between each.
- Send 4 flits on VC 0 with no credits returned -> irdy_o[0]=0, and a requester targeting VC 0 gets no grant. Pulse credit_i[0] -> irdy_o[0]=1 next cycle, then the grant follows.
- send_i on VC 0 together with credit_i[0] while cnt=2 -> cnt stays 2, err_o=0.
- credit_i[1] while cnt[1]=4 -> err_o=1, cnt stays 4. Send while in IDLE -> err_o=1.
- Reset asserted mid-packet while BUSY with ilck_o=01 -> outputs return to grt_o=0, ilck_o=0, irdy_o=11 without waiting for a clock edge.
